// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider with a start/ready/done
// handshake. One trial subtraction and one quotient bit are produced per clock.
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH+1:0] ONE = {{(WIDTH+1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  // The stored partial remainder is always below the divisor, so its top
  // bit is structurally zero and never read back.
  logic unused_r_top;
  assign unused_r_top = r_q[WIDTH];

  // Trial subtraction R' + ~{0,D} + 1; carry-out set means no borrow.
  always_comb begin
    r_shift   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial     = {1'b0, r_shift} + {1'b0, ~{1'b0, d_q}} + ONE;
    no_borrow = trial[WIDTH+1];
    r_next    = no_borrow ? trial[WIDTH:0] : r_shift;
    q_next    = {q_q[WIDTH-2:0], no_borrow};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          q_d   = dividend;
          d_d   = divisor;
          r_d   = '0;
          cnt_d = CW'(WIDTH);
          dz_d  = 1'b0;
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quot_d  = q_next;
          rem_d   = r_next[WIDTH-1:0];
          dz_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    ready     = (state_q == IDLE) || (state_q == DONE);
    done      = (state_q == DONE);
    quotient  = quot_q;
    remainder = rem_q;
    dz        = dz_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an
// arithmetic reference model (integer / and %, cycle-count latency).
module tb_seq_divider;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dz;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs for the current cycle.
  logic         m_ready = 1'b1;
  logic         m_done = 1'b0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_r = '0;
  logic         m_dz = 1'b0;
  logic [W-1:0] p_q, p_r;
  int           busy_left = 0;
  int           outstanding = 0;

  // Compare process: inputs are stable at the falling edge, so check the
  // current cycle and then predict what the next rising edge produces.
  always @(negedge clk) begin
    logic nr, nd;
    if (rst) begin
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_dz", 32'(dz), 32'd0);
      m_ready = 1'b1; m_done = 1'b0; m_q = '0; m_r = '0; m_dz = 1'b0;
      busy_left = 0; outstanding = 0;
    end else begin
      chk("ready", 32'(ready), 32'(m_ready));
      chk("done", 32'(done), 32'(m_done));
      chk("quotient", 32'(quotient), 32'(m_q));
      chk("remainder", 32'(remainder), 32'(m_r));
      if (m_done) chk("dz", 32'(dz), 32'(m_dz));
      if (done) begin
        chk("accepts_per_done", 32'(outstanding), 32'd1);
        outstanding--;
      end
      nd = 1'b0;
      nr = 1'b1;
      if (m_ready && start) begin
        outstanding++;
        if (divisor == '0) begin
          nd = 1'b1; m_q = '1; m_r = dividend; m_dz = 1'b1;
        end else begin
          nr = 1'b0; busy_left = W;
          p_q = dividend / divisor;
          p_r = dividend % divisor;
        end
      end else if (!m_ready) begin
        busy_left--;
        if (busy_left == 0) begin
          nd = 1'b1; m_q = p_q; m_r = p_r; m_dz = 1'b0;
        end else begin
          nr = 1'b0;
        end
      end
      m_ready = nr;
      m_done = nd;
    end
  end

  // One operation with literal expectations and latency counted in edges
  // including the accept edge.
  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input int elat);
    int lat;
    @(posedge clk);
    #2;
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(elat));
    chk({nm, "_q"}, 32'(quotient), 32'(eq));
    chk({nm, "_r"}, 32'(remainder), 32'(er));
    chk({nm, "_dz"}, 32'(dz), 32'(edz));
    if (b != '0) begin
      chk({nm, "_invariant"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      chk({nm, "_rem_lt_div"}, 32'(remainder < b), 32'd1);
    end
  endtask

  function automatic logic [W-1:0] pick();
    int unsigned sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0: return '0;
      1: return '1;
      2: return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int last;
    logic [W-1:0] a, b;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    run_op("basic", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
    run_op("ffff_div_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17);
    run_op("5_div_ffff", 16'h0005, 16'hFFFF, 16'h0000, 16'h0005, 1'b0, 17);
    run_op("ffff_div_ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17);
    run_op("div_zero", 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1);
    run_op("after_dz", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17);

    // start held high with operands changing every cycle
    @(posedge clk);
    #2;
    start = 1'b1; dividend = W'($urandom); divisor = W'($urandom_range(1, 65535));
    last = -1;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (last >= 0) chk("held_start_period", 32'(c - last), 32'd17);
        last = c;
      end
      #1;
      dividend = W'($urandom); divisor = W'($urandom_range(1, 65535));
    end
    start = 1'b0;
    repeat (20) @(posedge clk);

    // asynchronous reset in the middle of iteration 8
    @(posedge clk);
    #2;
    dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_q", 32'(quotient), 32'd0);
    chk("async_rst_r", 32'(remainder), 32'd0);
    chk("async_rst_ready", 32'(ready), 32'd1);
    chk("async_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(posedge clk);
    run_op("post_reset", 16'd50, 16'd6, 16'd8, 16'd2, 1'b0, 17);

    for (int i = 0; i < 2000; i++) begin
      a = pick();
      b = pick();
      if (b == '0)
        run_op("rand", a, b, '1, a, 1'b1, 1);
      else
        run_op("rand", a, b, a / b, a % b, 1'b0, 17);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
